// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared state encoding and lane-merge helper for the dual-port
//               data memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

    // One byte lane: the new byte replaces the old one when its mask bit is set.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_lane,
        input logic [7:0] new_lane,
        input logic       mask
    );
        return mask ? new_lane : old_lane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_write_merge.sv
// ============================================================================
// Module      : dmem_write_merge
// Description : Combinational post-write word for one memory word. Port 0 is
//               applied first and port 1 second, so port 1 wins overlapping lanes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_write_merge
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_cur_word,
    input  logic [DATA_WIDTH-1:0]   i_wdata0,
    input  logic [DATA_WIDTH/8-1:0] i_mask0,
    input  logic                    i_hit0,
    input  logic [DATA_WIDTH-1:0]   i_wdata1,
    input  logic [DATA_WIDTH/8-1:0] i_mask1,
    input  logic                    i_hit1,
    output logic [DATA_WIDTH-1:0]   o_word
);

    localparam int C_BYTES = DATA_WIDTH / 8;

    logic [7:0] w_lane;

    always_comb begin
        o_word = '0;
        w_lane = '0;
        for (int i = 0; i < C_BYTES; i++) begin
            w_lane          = byte_merge(i_cur_word[8*i +: 8], i_wdata0[8*i +: 8], i_mask0[i] & i_hit0);
            o_word[8*i +: 8] = byte_merge(w_lane, i_wdata1[8*i +: 8], i_mask1[i] & i_hit1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dual_port_data_memory.sv
// ============================================================================
// Module      : dual_port_data_memory
// Description : Two-port byte-maskable data memory with registered write-first
//               reads, alignment faults and a post-reset zero-clear sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dual_port_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_BYTES * 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    busy,
    input  logic                    write0,
    input  logic                    read_en0,
    input  logic [DATA_WIDTH/8-1:0] byte_en0,
    input  logic [ADDR_WIDTH-1:0]   address0,
    input  logic [DATA_WIDTH-1:0]   write_data0,
    output logic [DATA_WIDTH-1:0]   read_data0,
    output logic                    misaligned0,
    input  logic                    write1,
    input  logic                    read_en1,
    input  logic [DATA_WIDTH/8-1:0] byte_en1,
    input  logic [ADDR_WIDTH-1:0]   address1,
    input  logic [DATA_WIDTH-1:0]   write_data1,
    output logic [DATA_WIDTH-1:0]   read_data1,
    output logic                    misaligned1
);

    localparam int C_BYTES = DATA_WIDTH / 8;
    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_OFF_W = $clog2(C_BYTES);

    dmem_state_t             r_state;
    dmem_state_t             w_state_next;
    logic [C_IDX_W-1:0]      r_clear_idx;
    logic [C_IDX_W-1:0]      w_clear_idx_next;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data [2];
    logic [1:0]              r_misaligned;

    logic [ADDR_WIDTH-1:0]   w_addr  [2];
    logic [DATA_WIDTH-1:0]   w_wdata [2];
    logic [C_BYTES-1:0]      w_be    [2];
    logic [C_IDX_W-1:0]      w_idx   [2];
    logic [DATA_WIDTH-1:0]   w_fwd   [2];
    logic [1:0]              w_wr;
    logic [1:0]              w_rd_en;
    logic [1:0]              w_off_bad;
    logic [1:0]              w_access;
    logic [1:0]              w_hit;

    assign w_addr[0]  = address0;
    assign w_addr[1]  = address1;
    assign w_wdata[0] = write_data0;
    assign w_wdata[1] = write_data1;
    assign w_be[0]    = byte_en0;
    assign w_be[1]    = byte_en1;
    assign w_wr       = {write1, write0};
    assign w_rd_en    = {read_en1, read_en0};

    assign busy        = reset | (r_state == CLEAR);
    assign read_data0  = r_rd_data[0];
    assign read_data1  = r_rd_data[1];
    assign misaligned0 = r_misaligned[0];
    assign misaligned1 = r_misaligned[1];

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            assign w_idx[p]    = w_addr[p][C_IDX_W+C_OFF_W-1:C_OFF_W];
            assign w_access[p] = w_wr[p] | w_rd_en[p];
            // A store lands only when aligned, idle of reset and past the clear sequence.
            assign w_hit[p]    = w_wr[p] & ~w_off_bad[p] & ~reset & (r_state == READY);

            if (C_OFF_W > 0) begin : g_off
                assign w_off_bad[p] = |w_addr[p][C_OFF_W-1:0];
            end else begin : g_no_off
                assign w_off_bad[p] = 1'b0;
            end

            dmem_write_merge #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_merge (
                .i_cur_word (r_mem[w_idx[p]]),
                .i_wdata0   (w_wdata[0]),
                .i_mask0    (w_be[0]),
                .i_hit0     (w_hit[0] & (w_idx[0] == w_idx[p])),
                .i_wdata1   (w_wdata[1]),
                .i_mask1    (w_be[1]),
                .i_hit1     (w_hit[1] & (w_idx[1] == w_idx[p])),
                .o_word     (w_fwd[p])
            );
        end

        if (ADDR_WIDTH > C_IDX_W + C_OFF_W) begin : g_addr_high
            logic w_unused_addr_high;
            assign w_unused_addr_high = ^{address0[ADDR_WIDTH-1:C_IDX_W+C_OFF_W],
                                          address1[ADDR_WIDTH-1:C_IDX_W+C_OFF_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_idx <= w_clear_idx_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        case (r_state)
            CLEAR: begin
                w_clear_idx_next = r_clear_idx + 1'b1;
                if (r_clear_idx == C_IDX_W'(DEPTH - 1)) begin
                    w_state_next = READY;
                end
            end
            READY:   w_state_next = READY;
            default: w_state_next = CLEAR;
        endcase
    end

    // Both ports write the fully merged word, so a same-word pair stores identical data.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clear_idx] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_hit[p]) begin
                    r_mem[w_idx[p]] <= w_fwd[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == CLEAR)) begin
            r_rd_data[0] <= '0;
            r_rd_data[1] <= '0;
            r_misaligned <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_misaligned[p] <= w_access[p] & w_off_bad[p];
                if (w_access[p] && w_off_bad[p]) begin
                    r_rd_data[p] <= '0;
                end else if (w_rd_en[p]) begin
                    r_rd_data[p] <= w_fwd[p];
                end
            end
        end
    end

endmodule

`default_nettype wire
